pc_next_unit: RTL
=================

Name: pc_next_unit

Overview:
- Program-counter stage of the 31-instruction single-cycle MIPS core; sits directly downstream of the ALU.
- Consumes the ALU `zero` flag plus decoded control to select the next PC (sequential, BEQ/BNE, J/JAL, JR/JALR).
- Owns the PC register and the instruction-fetch request toward instruction memory, with stall, halt and misalignment handling.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  core enable; PC advances only when high.
- pc_src  input  3  next-PC select (encodings in package).
- alu_zero  input  1  ALU zero flag for the instruction in execute.
- imm16  input  16  branch offset field.
- jidx  input  26  jump index field.
- rs_val  input  32  register rs value for JR/JALR.
- imem_ready  input  1  instruction memory has the word at `pc` available.
- pc  output  32  current PC (registered).
- link_addr  output  32  pc+4, combinational, used as the JAL/JALR write-back value.
- imem_req  output  1  fetch request for `pc`.
- taken  output  1  combinational; the selected next PC differs from pc+4.
- halted  output  1  high in S_HALT.
- misalign  output  1  one-cycle pulse on a JR/JALR target with rs_val[1:0]≠0.
- retire_cnt  output  CNT_W  count of PC advances.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, imem_req=0, halted=0, misalign=0, retire_cnt=0, state=S_BOOT. Reset mid-stall or while halted has the same effect.
- FSM states: S_BOOT, S_RUN, S_HALT.
- S_BOOT: lasts one cycle with imem_req=0, then moves to S_RUN. The PC holds.
- S_RUN: imem_req=1. "Advance" means ena=1 and imem_ready=1. On advance, pc<=npc and retire_cnt<=retire_cnt+1. Otherwise pc and the counter hold, i.e. a stall. Inputs are sampled only on the advance cycle.
- Next-PC rules (all arithmetic mod 2^32):
  - p4 = pc+4, so 32'hFFFF_FFFC wraps to 0.
  - SEQ: p4.
  - BEQ: p4 + (sext(imm16)<<2) if alu_zero, else p4.
  - BNE: the same target if !alu_zero, else p4.
  - J/JAL: {p4[31:28], jidx, 2'b00}.
  - JR/JALR: rs_val.
  - BREAK: no advance; go to S_HALT on the advance condition.
- JR/JALR with rs_val[1:0]≠0 on an advance cycle: pc holds, misalign pulses high for exactly one cycle, state goes to S_HALT, and retire_cnt does not increment.
- S_HALT: imem_req=0, halted=1. pc and retire_cnt are frozen. Only rst_n exits this state.
- taken is computed from the current inputs whether or not an advance occurs. It is 0 in S_BOOT and S_HALT.
- retire_cnt wraps from all-ones to 0.
- Latency: a decision made on an advance cycle is visible on `pc` one clock later.
- Invalid pc_src encodings are treated as SEQ.

Decomposition:
- Package pc_pkg holds:
  - PCS_SEQ=0, PCS_BEQ=1, PCS_BNE=2, PCS_J=3, PCS_JAL=4, PCS_JR=5, PCS_JALR=6, PCS_BREAK=7.
  - FSM state encodings.
  - RESET_PC default.
- One sub-module, npc_calc: purely combinational target and taken computation. The FSM, PC register and counter stay in pc_next_unit.

Test Plan:
- Release reset: pc=0x0040_0000, imem_req=0 for one cycle, then 1. With ena=imem_ready=1 and SEQ for 3 cycles, pc=0x0040_000C and retire_cnt=3.
- At pc=0x0040_0010, BEQ with imm16=16'hFFFC and alu_zero=1: pc becomes 0x0040_0004 and taken=1. Same setup with BNE and alu_zero=1: pc becomes 0x0040_0014 and taken=0.
- J with jidx=26'h010_0008 at pc=0x0040_0000: pc becomes 0x0040_0020. JR with rs_val=0x0040_0100: pc becomes 0x0040_0100.
- Hold imem_ready=0 for 4 cycles during BEQ-taken: pc and retire_cnt are unchanged and imem_req stays 1. Raise imem_ready: the branch target loads on the next edge.
- JR with rs_val=0x0040_0102: misalign pulses one cycle, halted=1, pc is unchanged, imem_req=0. Pulse rst_n low mid-halt: full reset values return.
- BREAK: halted=1 and pc frozen despite ena=1. At pc=0xFFFF_FFFC with SEQ, the next pc is 0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared encodings for the PC stage: next-PC select codes, FSM states, reset vector
// and the branch-offset helper used by the target calculator.
package pc_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;

    typedef enum logic [2:0] {
        PCS_SEQ   = 3'd0,
        PCS_BEQ   = 3'd1,
        PCS_BNE   = 3'd2,
        PCS_J     = 3'd3,
        PCS_JAL   = 3'd4,
        PCS_JR    = 3'd5,
        PCS_JALR  = 3'd6,
        PCS_BREAK = 3'd7
    } pc_src_e;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    // Word offset of a branch: sign-extended immediate scaled by four.
    function automatic logic [31:0] branch_off(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_unit_npc_calc.sv
// Combinational next-PC target and taken detection for the PC stage.
module npc_calc
    import pc_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [2:0]  pc_src,
    input  logic        alu_zero,
    input  logic [15:0] imm16,
    input  logic [25:0] jidx,
    input  logic [31:0] rs_val,
    output logic [31:0] p4,
    output logic [31:0] npc,
    output logic        taken_raw
);

    logic [31:0] br_tgt_s;

    assign p4       = pc + 32'd4;
    assign br_tgt_s = p4 + branch_off(imm16);

    // Target selection; BREAK targets the current PC because the PC does not move.
    always_comb begin
        npc = p4;
        case (pc_src)
            PCS_SEQ: npc = p4;
            PCS_BEQ: begin
                if (alu_zero) npc = br_tgt_s;
                else          npc = p4;
            end
            PCS_BNE: begin
                if (!alu_zero) npc = br_tgt_s;
                else           npc = p4;
            end
            PCS_J, PCS_JAL:     npc = {p4[31:28], jidx, 2'b00};
            PCS_JR, PCS_JALR:   npc = rs_val;
            PCS_BREAK:          npc = pc;
            default:            npc = p4;
        endcase
    end

    assign taken_raw = (npc != p4);

endmodule

// File: rtl/pc_next_unit.sv
// PC register, fetch-request FSM and retired-instruction counter of the single-cycle core.
module pc_next_unit
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [2:0]       pc_src,
    input  logic             alu_zero,
    input  logic [15:0]      imm16,
    input  logic [25:0]      jidx,
    input  logic [31:0]      rs_val,
    input  logic             imem_ready,
    output logic [31:0]      pc,
    output logic [31:0]      link_addr,
    output logic             imem_req,
    output logic             taken,
    output logic             halted,
    output logic             misalign,
    output logic [CNT_W-1:0] retire_cnt
);

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             misalign_q, misalign_d;

    logic [31:0] p4_s, npc_s;
    logic        taken_raw_s, advance_s, is_jr_s, bad_jr_s, is_brk_s;

    npc_calc u_npc_calc (
        .pc        (pc_q),
        .pc_src    (pc_src),
        .alu_zero  (alu_zero),
        .imm16     (imm16),
        .jidx      (jidx),
        .rs_val    (rs_val),
        .p4        (p4_s),
        .npc       (npc_s),
        .taken_raw (taken_raw_s)
    );

    assign advance_s = ena && imem_ready;
    assign is_jr_s   = (pc_src == PCS_JR) || (pc_src == PCS_JALR);
    assign bad_jr_s  = is_jr_s && (rs_val[1:0] != 2'b00);
    assign is_brk_s  = (pc_src == PCS_BREAK);

    // Next-state logic: only an advance cycle in S_RUN moves the PC, counter or state.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        misalign_d = 1'b0;
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                if (advance_s) begin
                    if (is_brk_s || bad_jr_s) begin
                        state_d    = S_HALT;
                        misalign_d = bad_jr_s;
                    end else begin
                        pc_d  = npc_s;
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // State, PC, counter and misalign-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            cnt_q      <= {CNT_W{1'b0}};
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc         = pc_q;
    assign link_addr  = p4_s;
    assign imem_req   = (state_q == S_RUN);
    assign halted     = (state_q == S_HALT);
    assign taken      = (state_q == S_RUN) && taken_raw_s;
    assign misalign   = misalign_q;
    assign retire_cnt = cnt_q;

endmodule
